pdp8_memory: RTL and testbench

Memory responder for the PDP-8 core. It serves the instruction-fetch read port from instr_decode and the execute read/write ports from instr_exec, backed by a MEM_DEPTH x 12-bit word array. After reset it clears the array with an internal state machine. It also exposes a preload port for bench program loading, plus access counters and an error flag. In top it is the far end of the ifu_rd_* and exec_* buses.

---
 rtl/pdp8_pkg.sv | 17 +
 rtl/pdp8_sat_counter.sv | 27 ++
 rtl/pdp8_memory.sv | 161 ++++++++++++++++
 tb/tb_pdp8_memory.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 types and constants: bus widths, memory state encoding, address range check.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;
   typedef enum logic {MEM_CLEAR, MEM_READY} mem_state_e;

   localparam int PDP8_MEM_DEPTH = 4096;

   function automatic logic addr_legal(input logic [`ADDR_WIDTH-1:0] addr, input int depth);
      return int'(addr) < depth;
   endfunction
endpackage

// File: rtl/pdp8_sat_counter.sv
// Up-counter that adds 0..3 per cycle and sticks at all-ones instead of wrapping.
module pdp8_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       inc,
   output logic [WIDTH-1:0] cnt
);
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH+1:0] w_sum;

   // Two guard bits so any carry out of WIDTH is visible, even for tiny WIDTH.
   assign w_sum = {2'b00, r_cnt} + {{WIDTH{1'b0}}, inc};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (w_sum[WIDTH+1:WIDTH] != 2'b00) begin
         r_cnt <= '1;
      end else begin
         r_cnt <= w_sum[WIDTH-1:0];
      end
   end

   assign cnt = r_cnt;
endmodule

// File: rtl/pdp8_memory.sv
// PDP-8 word memory: two registered read ports, one exec write port, a loader port,
// a post-reset clear sweep, saturating access counters and a sticky error flag.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp8_memory
   import pdp8_pkg::*;
#(
   parameter int MEM_DEPTH      = PDP8_MEM_DEPTH,
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   ifu_rd_req,
   input  logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
   output logic [`DATA_WIDTH-1:0] ifu_rd_data,
   input  logic                   exec_rd_req,
   input  logic [`ADDR_WIDTH-1:0] exec_rd_addr,
   output logic [`DATA_WIDTH-1:0] exec_rd_data,
   input  logic                   exec_wr_req,
   input  logic [`ADDR_WIDTH-1:0] exec_wr_addr,
   input  logic [`DATA_WIDTH-1:0] exec_wr_data,
   input  logic                   ld_req,
   input  logic [`ADDR_WIDTH-1:0] ld_addr,
   input  logic [`DATA_WIDTH-1:0] ld_data,
   output logic                   mem_ready,
   output logic [CNT_WIDTH-1:0]   rd_cnt,
   output logic [CNT_WIDTH-1:0]   wr_cnt,
   output logic                   err_flag
);
   localparam int AW = `ADDR_WIDTH;
   localparam int DW = `DATA_WIDTH;
   localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

   logic [DW-1:0] r_mem [MEM_DEPTH];

   mem_state_e    r_state, w_state_next;
   logic [AW-1:0] r_clr_ptr, w_clr_ptr_next;
   logic          r_ready, r_err, w_err_next;
   logic [DW-1:0] r_ifu_data, w_ifu_data_next;
   logic [DW-1:0] r_exr_data, w_exr_data_next;

   logic          w_ifu_legal, w_exr_legal, w_ew_legal, w_ld_legal;
   logic          w_ifu_ok, w_exr_ok, w_wr_en, w_wr_accept;
   logic [AW-1:0] w_wr_addr;
   logic [DW-1:0] w_wr_data, w_ifu_word, w_exr_word;
   logic [1:0]    w_rd_inc, w_wr_inc;

   assign w_ifu_legal = addr_legal(ifu_rd_addr, MEM_DEPTH);
   assign w_exr_legal = addr_legal(exec_rd_addr, MEM_DEPTH);
   assign w_ew_legal  = addr_legal(exec_wr_addr, MEM_DEPTH);
   assign w_ld_legal  = addr_legal(ld_addr, MEM_DEPTH);

   // Write-first: a read colliding with this cycle's write sees the new data.
   assign w_ifu_word = (w_wr_en && w_wr_addr == ifu_rd_addr)  ? w_wr_data : r_mem[ifu_rd_addr];
   assign w_exr_word = (w_wr_en && w_wr_addr == exec_rd_addr) ? w_wr_data : r_mem[exec_rd_addr];

   always_comb begin
      w_state_next    = r_state;
      w_clr_ptr_next  = r_clr_ptr;
      w_err_next      = r_err;
      w_ifu_data_next = r_ifu_data;
      w_exr_data_next = r_exr_data;
      w_wr_en         = 1'b0;
      w_wr_accept     = 1'b0;
      w_wr_addr       = r_clr_ptr;
      w_wr_data       = '0;
      w_ifu_ok        = 1'b0;
      w_exr_ok        = 1'b0;
      case (r_state)
         MEM_CLEAR: begin
            w_wr_en        = 1'b1;
            w_clr_ptr_next = r_clr_ptr + AW'(1);
            if (r_clr_ptr == LAST_ADDR) begin
               w_state_next = MEM_READY;
            end
            if (ifu_rd_req || exec_rd_req || exec_wr_req || ld_req) begin
               w_err_next = 1'b1;
            end
         end
         MEM_READY: begin
            if (exec_wr_req) begin
               w_wr_en   = w_ew_legal;
               w_wr_addr = exec_wr_addr;
               w_wr_data = exec_wr_data;
            end else if (ld_req) begin
               w_wr_en   = w_ld_legal;
               w_wr_addr = ld_addr;
               w_wr_data = ld_data;
            end
            w_wr_accept = w_wr_en;
            w_ifu_ok    = ifu_rd_req && w_ifu_legal;
            w_exr_ok    = exec_rd_req && w_exr_legal;
            if (ifu_rd_req) begin
               w_ifu_data_next = w_ifu_legal ? w_ifu_word : '0;
            end
            if (exec_rd_req) begin
               w_exr_data_next = w_exr_legal ? w_exr_word : '0;
            end
            if ((ifu_rd_req && !w_ifu_legal) || (exec_rd_req && !w_exr_legal) ||
                (exec_wr_req && !w_ew_legal) || (ld_req && !w_ld_legal) ||
                (ld_req && exec_wr_req)) begin
               w_err_next = 1'b1;
            end
         end
         default: w_state_next = MEM_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= CLEAR_ON_RESET ? MEM_CLEAR : MEM_READY;
         r_clr_ptr  <= '0;
         r_ready    <= 1'b0;
         r_err      <= 1'b0;
         r_ifu_data <= '0;
         r_exr_data <= '0;
      end else begin
         r_state    <= w_state_next;
         r_clr_ptr  <= w_clr_ptr_next;
         r_ready    <= (w_state_next == MEM_READY);
         r_err      <= w_err_next;
         r_ifu_data <= w_ifu_data_next;
         r_exr_data <= w_exr_data_next;
      end
   end

   // Gated by reset_n so no write lands on an edge while reset is held.
   always_ff @(posedge clk) begin
      if (w_wr_en && reset_n) begin
         r_mem[w_wr_addr] <= w_wr_data;
      end
   end

   assign w_rd_inc = {1'b0, w_ifu_ok} + {1'b0, w_exr_ok};
   assign w_wr_inc = {1'b0, w_wr_accept};

   pdp8_sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (w_rd_inc),
      .cnt     (rd_cnt)
   );

   pdp8_sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (w_wr_inc),
      .cnt     (wr_cnt)
   );

   assign ifu_rd_data  = r_ifu_data;
   assign exec_rd_data = r_exr_data;
   assign mem_ready    = r_ready;
   assign err_flag     = r_err;
endmodule

// File: tb/tb_pdp8_memory.sv
// Bench for pdp8_memory: a full-size instance and a small (depth 100, 4-bit counter) instance
// share all stimulus and are both tracked by a word-level reference model.
module tb_pdp8_memory;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ifu_req = 1'b0, er_req = 1'b0, ew_req = 1'b0, ld_req = 1'b0;
   logic [11:0] ifu_addr = '0, er_addr = '0, ew_addr = '0, ew_data = '0, ld_addr = '0, ld_data = '0;

   logic [11:0] ifu_q [2];
   logic [11:0] exr_q [2];
   logic        rdy_q [2];
   logic        err_q [2];
   logic [15:0] rd_q0, wr_q0;
   logic [3:0]  rd_q1, wr_q1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pdp8_memory dut_full (
      .clk(clk), .reset_n(reset_n),
      .ifu_rd_req(ifu_req), .ifu_rd_addr(ifu_addr), .ifu_rd_data(ifu_q[0]),
      .exec_rd_req(er_req), .exec_rd_addr(er_addr), .exec_rd_data(exr_q[0]),
      .exec_wr_req(ew_req), .exec_wr_addr(ew_addr), .exec_wr_data(ew_data),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
      .mem_ready(rdy_q[0]), .rd_cnt(rd_q0), .wr_cnt(wr_q0), .err_flag(err_q[0])
   );

   pdp8_memory #(.MEM_DEPTH(100), .CLEAR_ON_RESET(1'b1), .CNT_WIDTH(4)) dut_small (
      .clk(clk), .reset_n(reset_n),
      .ifu_rd_req(ifu_req), .ifu_rd_addr(ifu_addr), .ifu_rd_data(ifu_q[1]),
      .exec_rd_req(er_req), .exec_rd_addr(er_addr), .exec_rd_data(exr_q[1]),
      .exec_wr_req(ew_req), .exec_wr_addr(ew_addr), .exec_wr_data(ew_data),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
      .mem_ready(rdy_q[1]), .rd_cnt(rd_q1), .wr_cnt(wr_q1), .err_flag(err_q[1])
   );

   // Reference model: word arrays plus per-instance bookkeeping.
   int m_mem [2][4096];
   int m_ifu [2], m_exr [2], m_rd [2], m_wr [2], m_err [2], m_clr [2];
   int m_depth [2] = '{4096, 100};
   int m_cmax  [2] = '{65535, 15};

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ifu[d] = 0; m_exr[d] = 0; m_rd[d] = 0; m_wr[d] = 0; m_err[d] = 0;
         m_clr[d] = m_depth[d];
      end
   endtask

   // One clock edge using the currently driven inputs: write first, then read.
   task automatic model_step();
      int dep;
      if (!reset_n) begin
         model_reset();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         dep = m_depth[d];
         if (m_clr[d] > 0) begin
            if (ifu_req || er_req || ew_req || ld_req) m_err[d] = 1;
            m_mem[d][dep - m_clr[d]] = 0;
            m_clr[d] = m_clr[d] - 1;
         end else begin
            if (ew_req) begin
               if (int'(ew_addr) < dep) begin
                  m_mem[d][ew_addr] = int'(ew_data);
                  m_wr[d] = (m_wr[d] + 1 > m_cmax[d]) ? m_cmax[d] : m_wr[d] + 1;
               end else m_err[d] = 1;
               if (ld_req) m_err[d] = 1;
            end else if (ld_req) begin
               if (int'(ld_addr) < dep) begin
                  m_mem[d][ld_addr] = int'(ld_data);
                  m_wr[d] = (m_wr[d] + 1 > m_cmax[d]) ? m_cmax[d] : m_wr[d] + 1;
               end else m_err[d] = 1;
            end
            if (ifu_req) begin
               if (int'(ifu_addr) < dep) begin
                  m_ifu[d] = m_mem[d][ifu_addr];
                  m_rd[d] = (m_rd[d] + 1 > m_cmax[d]) ? m_cmax[d] : m_rd[d] + 1;
               end else begin
                  m_ifu[d] = 0; m_err[d] = 1;
               end
            end
            if (er_req) begin
               if (int'(er_addr) < dep) begin
                  m_exr[d] = m_mem[d][er_addr];
                  m_rd[d] = (m_rd[d] + 1 > m_cmax[d]) ? m_cmax[d] : m_rd[d] + 1;
               end else begin
                  m_exr[d] = 0; m_err[d] = 1;
               end
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("ifu_data[%0d]", d), 32'(ifu_q[d]), m_ifu[d]);
         chk($sformatf("exec_data[%0d]", d), 32'(exr_q[d]), m_exr[d]);
         chk($sformatf("mem_ready[%0d]", d), 32'(rdy_q[d]), (m_clr[d] == 0 && reset_n) ? 1 : 0);
         chk($sformatf("err_flag[%0d]", d), 32'(err_q[d]), m_err[d]);
      end
      chk("rd_cnt[0]", 32'(rd_q0), m_rd[0]);
      chk("wr_cnt[0]", 32'(wr_q0), m_wr[0]);
      chk("rd_cnt[1]", 32'(rd_q1), m_rd[1]);
      chk("wr_cnt[1]", 32'(wr_q1), m_wr[1]);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle();
      ifu_req = 1'b0; er_req = 1'b0; ew_req = 1'b0; ld_req = 1'b0;
   endtask

   task automatic sweep_to_ready(input string tag);
      for (int c = 1; c <= 4096; c++) begin
         cycle();
         if (c == 4095) chk({tag, "_ready_low_4095"}, 32'(rdy_q[0]), 0);
         if (c == 4096) chk({tag, "_ready_high_4096"}, 32'(rdy_q[0]), 1);
      end
   endtask

   typedef struct {
      logic ifu_req; logic [11:0] ifu_addr;
      logic er_req;  logic [11:0] er_addr;
      logic ew_req;  logic [11:0] ew_addr; logic [11:0] ew_data;
      logic ld_req;  logic [11:0] ld_addr; logic [11:0] ld_data;
      logic [11:0] e_ifu; logic [11:0] e_exr;
      logic [15:0] e_rd;  logic [15:0] e_wr; logic e_err;
   } vec_t;

   vec_t vt [8];
   int   base;

   initial begin
      vt[0] = '{1'b0, 12'o0000, 1'b0, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b1, 12'o0200, 12'o7402,
                12'o0000, 12'o0000, 16'd0, 16'd1, 1'b0};
      vt[1] = '{1'b1, 12'o0200, 1'b0, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0, 12'o0000, 12'o0000,
                12'o7402, 12'o0000, 16'd1, 16'd1, 1'b0};
      vt[2] = '{1'b1, 12'o0100, 1'b1, 12'o0100, 1'b1, 12'o0100, 12'o1234, 1'b0, 12'o0000, 12'o0000,
                12'o1234, 12'o1234, 16'd3, 16'd2, 1'b0};
      vt[3] = '{1'b0, 12'o0000, 1'b0, 12'o0000, 1'b1, 12'o0050, 12'o0001, 1'b1, 12'o0050, 12'o0002,
                12'o1234, 12'o1234, 16'd3, 16'd3, 1'b1};
      vt[4] = '{1'b0, 12'o0000, 1'b1, 12'o0050, 1'b0, 12'o0000, 12'o0000, 1'b0, 12'o0000, 12'o0000,
                12'o1234, 12'o0001, 16'd4, 16'd3, 1'b1};
      vt[5] = '{1'b1, 12'o7777, 1'b0, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0, 12'o0000, 12'o0000,
                12'o0000, 12'o0001, 16'd5, 16'd3, 1'b1};
      vt[6] = '{1'b0, 12'o0000, 1'b0, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0, 12'o0000, 12'o0000,
                12'o0000, 12'o0001, 16'd5, 16'd3, 1'b1};
      vt[7] = '{1'b1, 12'o0200, 1'b1, 12'o0100, 1'b0, 12'o0000, 12'o0000, 1'b0, 12'o0000, 12'o0000,
                12'o7402, 12'o1234, 16'd7, 16'd3, 1'b1};

      // Reset held for a few edges, then a quiet clear sweep.
      model_reset();
      repeat (3) cycle();
      chk("reset_rd_cnt", 32'(rd_q0), 0);
      chk("reset_err", 32'(err_q[0]), 0);
      reset_n = 1'b1;
      sweep_to_ready("first");

      for (int i = 0; i < 8; i++) begin
         ifu_req = vt[i].ifu_req; ifu_addr = vt[i].ifu_addr;
         er_req  = vt[i].er_req;  er_addr  = vt[i].er_addr;
         ew_req  = vt[i].ew_req;  ew_addr  = vt[i].ew_addr; ew_data = vt[i].ew_data;
         ld_req  = vt[i].ld_req;  ld_addr  = vt[i].ld_addr; ld_data = vt[i].ld_data;
         cycle();
         chk($sformatf("vec%0d_ifu", i), 32'(ifu_q[0]), 32'(vt[i].e_ifu));
         chk($sformatf("vec%0d_exec", i), 32'(exr_q[0]), 32'(vt[i].e_exr));
         chk($sformatf("vec%0d_rd_cnt", i), 32'(rd_q0), 32'(vt[i].e_rd));
         chk($sformatf("vec%0d_wr_cnt", i), 32'(wr_q0), 32'(vt[i].e_wr));
         chk($sformatf("vec%0d_err", i), 32'(err_q[0]), 32'(vt[i].e_err));
         $display("vec %0d: ifu %o exec %o rd_cnt %0d wr_cnt %0d err %0d", i, ifu_q[0], exr_q[0],
                  rd_q0, wr_q0, err_q[0]);
      end
      idle();

      // Back-to-back fetches drive the 4-bit counter into saturation.
      ifu_req = 1'b1; ifu_addr = 12'd5;
      for (int i = 0; i < 20; i++) cycle();
      chk("sat_rd_cnt_w4", 32'(rd_q1), 32'hF);
      $display("saturation: small rd_cnt %0h full rd_cnt %0d", rd_q1, rd_q0);
      idle();

      // Random traffic clustered around the small instance's depth boundary.
      for (int t = 0; t < 300; t++) begin
         base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(90, 108));
         ifu_req = ($urandom_range(0, 1) == 1); ifu_addr = 12'(base + int'($urandom_range(0, 2)));
         er_req  = ($urandom_range(0, 1) == 1); er_addr  = 12'(base + int'($urandom_range(0, 2)));
         ew_req  = ($urandom_range(0, 2) == 0); ew_addr  = 12'(base + int'($urandom_range(0, 2)));
         ew_data = 12'($urandom);
         ld_req  = ($urandom_range(0, 3) == 0); ld_addr  = 12'(base + int'($urandom_range(0, 2)));
         ld_data = 12'($urandom);
         cycle();
         $display("rand %0d: ifu %0b@%0d er %0b@%0d ew %0b@%0d ld %0b@%0d -> ifu %o/%o exec %o/%o",
                  t, ifu_req, ifu_addr, er_req, er_addr, ew_req, ew_addr, ld_req, ld_addr,
                  ifu_q[0], ifu_q[1], exr_q[0], exr_q[1]);
      end
      idle();

      // Asynchronous reset mid-operation takes effect before the next edge.
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("async_reset_err", 32'(err_q[0]), 0);
      cycle();
      reset_n = 1'b1;
      repeat (10) cycle();

      // A fetch during CLEAR is refused and flagged.
      ifu_req = 1'b1; ifu_addr = 12'o0003;
      cycle();
      chk("clear_fetch_data", 32'(ifu_q[0]), 0);
      chk("clear_fetch_err", 32'(err_q[0]), 1);
      chk("clear_fetch_rd_cnt", 32'(rd_q0), 0);
      $display("fetch during clear: data %o err %0d", ifu_q[0], err_q[0]);
      idle();
      repeat (5) cycle();

      // Reset again mid-sweep: error clears and the full sweep restarts.
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("midclear_reset_err", 32'(err_q[0]), 0);
      cycle();
      reset_n = 1'b1;
      sweep_to_ready("restart");
      $display("restart sweep: mem_ready %0d after 4096 cycles", rdy_q[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
